pipe_adder: RTL
===============

Name: pipe_adder

Overview:
- Parametrised, chunk-pipelined adder/subtractor. Successor to the fixed 4-bit registered adder.
- The WIDTH-bit carry chain is split into CHUNK-bit slices, with one slice resolved per pipeline stage; the carry is registered between stages.
- Provides valid/ready flow control so it can sit directly in the BC-MAC accumulate datapath and take partial-product sums from the column compressors.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per pipeline stage; 1 <= CHUNK <= WIDTH.
- NSTG (localparam), WIDTH/CHUNK: number of carry stages.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add mode only)
- in_sub  in  1  1 = A-B, 0 = A+B+cin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out of the MSB (subtract mode: 1 = no borrow)
- out_ovf  out  1  signed overflow (present only with PIPE_ADD_SAT_EN)

Behaviour:
- Reset (asynchronous, rst_n=0): every pipeline register, including per-stage valid bits, clears to 0; out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - in_ready is 1 from the first cycle after reset deassertion.
  - Reset mid-operation discards all in-flight beats; no partial result ever appears.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - All stages shift together when adv=1 and hold when adv=0.
  - Bubbles are not collapsed.
- Accept: a beat is accepted when in_valid && in_ready.
  - Input stage 0 registers A, the effective B (~in_b if in_sub, else in_b), the effective cin (1 if in_sub, else in_cin), and valid.
- Stage k (1..NSTG):
  - Adds slice k-1 of A and effective B plus the carry from stage k-1 (stage 1 uses the effective cin).
  - Registers the CHUNK-bit slice result and the carry-out.
  - Carries the untouched upper operand slices and the already-resolved lower sum slices forward (skew/deskew registers).
- Output: the stage-NSTG registers drive out_sum, out_cout and out_valid directly.
- Latency: NSTG+1 clk edges from acceptance to out_valid with no stall; 5 for the defaults.
- Throughput: 1 beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - all stage contents and outputs hold stable;
  - in_ready=0;
  - in_a/in_b changes are ignored.
- Simultaneous pop and push in one cycle is legal; a full pipe sustains full rate.
- Arithmetic:
  - Modulo 2^WIDTH; out_cout = bit WIDTH of the full-precision sum.
  - out_sum is unsigned/two's-complement agnostic unless saturation is enabled.
- CHUNK==WIDTH degenerates to two register stages (input, one adder); it must still work.

Optional Feature:
- Macro PIPE_ADD_SAT_EN.
- Defined:
  - The final stage computes signed overflow as (sign A == sign effective B) && (sign sum != sign A).
  - The out_ovf port exists.
  - out_sum clamps to 0x7FFF / 0x8000 (for WIDTH=16) on positive/negative overflow.
  - out_cout is unchanged (raw).
- Undefined: no out_ovf port and no clamp logic; out_sum wraps.

Decomposition:
- Package pipe_adder_pkg: the default WIDTH/CHUNK constants, the derived-NSTG function, and the saturation min/max constants as functions of width.
- One natural sub-module, add_chunk_stage:
  - one CHUNK-bit slice add with registered sum, carry and valid;
  - shared adv enable;
  - generated NSTG times.

Test Plan:
- Defaults, out_ready=1: A=0x1234, B=0x0FFF, sub=0, cin=1 -> after 5 cycles out_sum=0x2234, out_cout=0.
- Full carry ripple: A=0xFFFF, B=0x0000, cin=1 -> out_sum=0x0000, out_cout=1; subtract A=0x0005, B=0x0007 -> out_sum=0xFFFE, out_cout=0.
- Back-to-back stream of 20 random beats with out_ready=1 -> 20 in-order results, one per cycle, matching the reference model.
- out_ready held low 3 cycles with a full pipe:
  - in_ready=0;
  - out_sum/out_valid stable;
  - no beat lost or duplicated after release.
- Assert rst_n low with 3 beats in flight -> out_valid=0 and out_sum=0 immediately; no stale beat emerges after release.
- With PIPE_ADD_SAT_EN: A=0x7FFF, B=0x0001 -> out_sum=0x7FFF, out_ovf=1; A=0x8000, sub with B=0x0001 -> out_sum=0x8000, out_ovf=1.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the chunk-pipelined adder/subtractor.
// The PIPE_ADD_SAT_EN build uses the saturation helpers below.
package pipe_adder_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_CHUNK = 4;
   localparam int unsigned MAX_W     = 64;

   function automatic int unsigned nstg(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   // Largest positive two's-complement value of the given width
   function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
      return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
   endfunction

   // Most negative two's-complement value of the given width
   function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
      return MAX_W'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/add_chunk_stage.sv
// One carry stage: resolves slice IDX of the sum and registers it along with
// the skewed operands, partial sum, carry and valid. PIPE_ADD_SAT_EN adds overflow/clamp on LAST.
module add_chunk_stage
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CHUNK = DEF_CHUNK,
   parameter int unsigned IDX   = 0
`ifdef PIPE_ADD_SAT_EN
   ,
   parameter bit          LAST  = 1'b0
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] prev_a,
   input  logic [WIDTH-1:0] prev_b,
   input  logic [WIDTH-1:0] prev_sum,
   input  logic             prev_carry,
   output logic             valid,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef PIPE_ADD_SAT_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned LO = IDX * CHUNK;
   localparam int unsigned SW = CHUNK + 1;

   logic [CHUNK:0]   slice_c;
   logic [WIDTH-1:0] sum_c;
   logic [WIDTH-1:0] res_c;

   // Slice add; lower slices already resolved, upper slices still pending
   always_comb begin
      slice_c = SW'(prev_a[LO +: CHUNK]) + SW'(prev_b[LO +: CHUNK]) + SW'(prev_carry);
      sum_c   = prev_sum;
      sum_c[LO +: CHUNK] = slice_c[CHUNK-1:0];
   end

`ifdef PIPE_ADD_SAT_EN
   logic ovf_c;

   // Signed overflow and clamp, only meaningful once the MSB slice is known
   always_comb begin
      ovf_c = 1'b0;
      res_c = sum_c;
      if (LAST) begin
         ovf_c = (prev_a[WIDTH-1] == prev_b[WIDTH-1]) && (sum_c[WIDTH-1] != prev_a[WIDTH-1]);
         if (ovf_c) begin
            res_c = prev_a[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (adv) begin
         ovf <= ovf_c;
      end
   end
`else
   assign res_c = sum_c;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         a     <= '0;
         b     <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else if (adv) begin
         valid <= prev_valid;
         a     <= prev_a;
         b     <= prev_b;
         sum   <= res_c;
         carry <= slice_c[CHUNK];
      end
   end

endmodule

// File: rtl/pipe_adder.sv
// Chunk-pipelined adder/subtractor with valid/ready flow control; all stages
// advance together. Define PIPE_ADD_SAT_EN for signed saturation and out_ovf.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PIPE_ADD_SAT_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int unsigned NSTG = nstg(WIDTH, CHUNK);

   logic             adv;
   logic             valid0_q;
   logic [WIDTH-1:0] a0_q;
   logic [WIDTH-1:0] b0_q;
   logic             cin0_q;

   logic             valid_w [NSTG+1];
   logic [WIDTH-1:0] a_w     [NSTG+1];
   logic [WIDTH-1:0] b_w     [NSTG+1];
   logic [WIDTH-1:0] sum_w   [NSTG+1];
   logic             carry_w [NSTG+1];
   logic             unused_tail;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Input stage: fold subtract into inverted B with carry-in forced high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid0_q <= 1'b0;
         a0_q     <= '0;
         b0_q     <= '0;
         cin0_q   <= 1'b0;
      end else if (adv) begin
         valid0_q <= in_valid;
         a0_q     <= in_a;
         b0_q     <= in_sub ? ~in_b : in_b;
         cin0_q   <= in_sub | in_cin;
      end
   end

   assign valid_w[0] = valid0_q;
   assign a_w[0]     = a0_q;
   assign b_w[0]     = b0_q;
   assign sum_w[0]   = '0;
   assign carry_w[0] = cin0_q;

`ifdef PIPE_ADD_SAT_EN
   logic [NSTG-1:0] ovf_w;
   logic            unused_ovf;
   assign unused_ovf = ^ovf_w;
   assign out_ovf    = ovf_w[NSTG-1];
`endif

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      add_chunk_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (k)
`ifdef PIPE_ADD_SAT_EN
         ,
         .LAST  (k == NSTG - 1)
`endif
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .adv        (adv),
         .prev_valid (valid_w[k]),
         .prev_a     (a_w[k]),
         .prev_b     (b_w[k]),
         .prev_sum   (sum_w[k]),
         .prev_carry (carry_w[k]),
         .valid      (valid_w[k+1]),
         .a          (a_w[k+1]),
         .b          (b_w[k+1]),
         .sum        (sum_w[k+1]),
         .carry      (carry_w[k+1])
`ifdef PIPE_ADD_SAT_EN
         ,
         .ovf        (ovf_w[k])
`endif
      );
   end

   // Operands leaving the last stage have no consumer
   assign unused_tail = ^{a_w[NSTG], b_w[NSTG]};

   assign out_valid = valid_w[NSTG];
   assign out_sum   = sum_w[NSTG];
   assign out_cout  = carry_w[NSTG];

endmodule
